// File: rtl/bpu_bht_btb_if.sv
// Bundle of the signals exchanged between the pipeline and the branch predictor.
//   if_pc_i          : PC being fetched (lookup address)
//   prd_jump_en_o    : predicted taken
//   prd_jump_addr_o  : predicted target (0 when not predicted taken)
//   upd_valid_i      : EX resolves a branch/jump this cycle
//   upd_pc_i         : PC of the resolving instruction
//   upd_taken_i      : actual outcome
//   upd_target_i     : actual target
//   upd_mispred_i    : controller prediction-fail flag
//   hold_i           : EX stage held; no training this cycle
//   mispred_cnt_o    : mispredicts since reset
//   branch_cnt_o     : resolved branches since reset
// Modports: master = pipeline side, slave = predictor side.
interface bpu_bht_btb_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] if_pc_i;
  logic              prd_jump_en_o;
  logic [ADDR_W-1:0] prd_jump_addr_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_mispred_i;
  logic              hold_i;
  logic [31:0]       mispred_cnt_o;
  logic [31:0]       branch_cnt_o;

  modport master (
    output if_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_mispred_i, hold_i,
    input  prd_jump_en_o, prd_jump_addr_o, mispred_cnt_o, branch_cnt_o
  );

  modport slave (
    input  if_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_mispred_i, hold_i,
    output prd_jump_en_o, prd_jump_addr_o, mispred_cnt_o, branch_cnt_o
  );
endinterface

// File: rtl/bpu_bht_btb.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// Lookup on if_pc_i is purely combinational on the registered table, so a
// same-cycle update is only visible from the following cycle and there is no
// path from upd_* to prd_*.
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : predictor side of bpu_bht_btb_if (lookup, training, statistics)
// Update handshake: an update is accepted on a rising clk edge where
// upd_valid_i=1 and hold_i=0; there is no back-pressure, a held update is
// simply dropped and EX re-presents it later.
module bpu_bht_btb #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = ADDR_W - INDEX_W - 2
) (
  input logic            clk,
  input logic            rstn,
  bpu_bht_btb_if.slave   bus
);
  localparam int ENTRIES = 2 ** INDEX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [31:0]        branch_cnt_q;
  logic [31:0]        mispred_cnt_q;

  // PC bits [1:0] never take part in indexing or tag compare.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc_i[1:0], bus.upd_pc_i[1:0]};

  // Lookup
  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;
  logic               lk_taken;

  assign lk_idx   = bus.if_pc_i[INDEX_W+1:2];
  assign lk_tag   = bus.if_pc_i[ADDR_W-1:INDEX_W+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ctr_q[lk_idx][1];

  assign bus.prd_jump_en_o   = lk_taken;
  assign bus.prd_jump_addr_o = lk_taken ? target_q[lk_idx] : '0;
  assign bus.branch_cnt_o    = branch_cnt_q;
  assign bus.mispred_cnt_o   = mispred_cnt_q;

  // Training
  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;
  logic               up_accept;

  assign up_idx    = bus.upd_pc_i[INDEX_W+1:2];
  assign up_tag    = bus.upd_pc_i[ADDR_W-1:INDEX_W+2];
  assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_accept = bus.upd_valid_i && !bus.hold_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (up_accept) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (bus.upd_mispred_i) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
      if (up_hit) begin
        if (bus.upd_taken_i) begin
          target_q[up_idx] <= bus.upd_target_i;
          if (ctr_q[up_idx] != 2'b11) begin
            ctr_q[up_idx] <= ctr_q[up_idx] + 2'b01;
          end
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - 2'b01;
        end
      end else if (bus.upd_taken_i) begin
        // Allocate on taken miss, evicting whatever aliases to this index.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bus.upd_target_i;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end
endmodule

// File: doc/bpu_bht_btb.md
Name: bpu_bht_btb

Overview:
- Dynamic branch predictor that produces the IF-stage prediction (`prd_jump_en`, predicted target) consumed by decode and the pipeline controller.
- Is trained by the EX-stage resolution results (actual jump enable, actual jump address, mispredict flag) that the controller computes.
- Direct-mapped branch target buffer; each entry holds a 2-bit saturating counter.
- Lookup is combinational on the IF PC; training is synchronous from EX.

Parameters:
- ADDR_W, 32, instruction address width.
- INDEX_W, 4, log2 of entry count (ENTRIES = 2**INDEX_W = 16).
- TAG_W, ADDR_W-INDEX_W-2, tag width; bits [1:0] of the PC are ignored.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- if_pc_i  in  ADDR_W  PC being fetched (lookup address).
- prd_jump_en_o  out  1  predicted taken (hit and counter[1]==1).
- prd_jump_addr_o  out  ADDR_W  predicted target; 0 when prd_jump_en_o=0.
- upd_valid_i  in  1  EX is resolving a branch/jump this cycle.
- upd_pc_i  in  ADDR_W  PC of the resolving instruction.
- upd_taken_i  in  1  actual outcome (EX jump enable).
- upd_target_i  in  ADDR_W  actual target (EX base+offset).
- upd_mispred_i  in  1  controller prediction-fail flag for this instruction.
- hold_i  in  1  EX stage held (hold_en[3]); suppresses training.
- mispred_cnt_o  out  32  count of mispredicts since reset.
- branch_cnt_o  out  32  count of resolved branches since reset.

Behaviour:
- Index = pc[INDEX_W+1:2]; tag = pc[ADDR_W-1:INDEX_W+2].
- Per entry: valid, tag, target[ADDR_W], ctr[1:0].
- Reset (rstn=0, asynchronous): all valid=0, all ctr=2'b01, all targets=0, both counters=0. Outputs go to 0 immediately because lookup is combinational on cleared state.
- Reset mid-operation: any in-flight update is discarded, with no partial write.
- Lookup has 0-cycle latency: hit = valid[idx] && tag match. prd_jump_en_o = hit && ctr[idx][1]. prd_jump_addr_o = prd_jump_en_o ? target[idx] : 0.
- Training happens on the rising edge where upd_valid_i=1 and hold_i=0:
  - Hit, taken: ctr increments, saturating at 2'b11; target <= upd_target_i.
  - Hit, not taken: ctr decrements, saturating at 2'b00; target unchanged; entry stays valid.
  - Miss, taken: allocate, overwriting any aliasing entry: valid=1, tag, target=upd_target_i, ctr=2'b10.
  - Miss, not taken: no table change.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff ctr[1].
- Same-cycle lookup and update to the same index: lookup returns pre-update contents, with no bypass. The new state is visible from the next cycle.
- hold_i=1 with upd_valid_i=1: no table write and no counter increment. EX re-presents the instruction later.
- branch_cnt_o increments by 1 per accepted update. mispred_cnt_o increments by 1 per accepted update with upd_mispred_i=1. Both wrap modulo 2**32 (0xFFFF_FFFF -> 0).
- upd_mispred_i has no effect on the table; training uses only upd_taken_i and upd_target_i.
- No X on outputs after reset. No combinational path exists from the upd_* inputs to prd_* outputs.

Test Plan:
- Reset, then if_pc_i=0x0000_0040 -> prd_jump_en_o=0, prd_jump_addr_o=0, branch_cnt_o=0, mispred_cnt_o=0.
- Update pc=0x40, taken, target=0x100, mispred=1, then lookup 0x40 next cycle -> prd_jump_en_o=1, addr=0x100, ctr=10, mispred_cnt_o=1, branch_cnt_o=1. Lookup 0x80 (same index 0, tag 2) -> miss, en=0.
- Hysteresis on pc=0x40 starting from ctr 10:
  - Three taken updates -> ctr saturates at 11.
  - One not-taken -> ctr 10, still predicts 0x100.
  - Two more not-taken -> ctr 00, en=0.
  - One taken -> ctr 01, en=0.
- Same-cycle lookup and update at pc=0x40 (ctr 01, taken): that cycle en=0; following cycle en=1.
- hold_i=1 with upd_valid_i=1, taken, pc=0x44 -> no allocation (lookup 0x44 en=0), branch_cnt_o unchanged. Release hold, repeat the update -> en=1.
- Train 4 entries, then pulse rstn low mid-cycle (asynchronous) -> prd_jump_en_o drops to 0 before the next clk edge, counters read 0, all entries miss after release.
